// File: rtl/decode_scan_ctrl.sv
//==============================================================================
// Module      : decode_scan_ctrl
// Description : Steps the 3-to-8 decoder select code (A,B,C) through 0..7 or
//               7..0 with a programmable dwell per code; single pass or loop.
//               Optional build macro SCAN_SKIP_EN adds a per-code skip mask.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module decode_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               dir,
    input  logic               loop,
    input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_SKIP_EN
    input  logic [7:0]         skip_mask,
`endif
    output logic               A,
    output logic               B,
    output logic               C,
    output logic               valid,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [DWELL_W-1:0] c_DWELL_ZERO = '0;
    localparam logic [DWELL_W-1:0] c_DWELL_ONE  = DWELL_W'(1);

    state_t             r_state;
    state_t             w_nxt_state;
    logic [2:0]         r_code;
    logic [2:0]         w_nxt_code;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_nxt_cnt;
    logic [DWELL_W-1:0] r_dwell_m1;
    logic [DWELL_W-1:0] w_nxt_dwell_m1;
    logic               r_dir;
    logic               w_nxt_dir;
    logic               r_loop;
    logic               w_nxt_loop;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;
    logic               w_nxt_done;
    logic               r_wrap;
    logic               w_nxt_wrap;

    logic [7:0]         w_mask_in;
    logic [7:0]         w_scan_mask;
    logic               w_accept;
    logic [3:0]         w_first_new;
    logic [3:0]         w_first_lat;
    logic [3:0]         w_next;

    // Returns {found, code}: nearest unmasked code from base in the scan
    // direction, including base itself when incl is set. No wrap-around.
    function automatic logic [3:0] scan_from(
        input logic [7:0] mask,
        input logic [2:0] base,
        input logic       down,
        input logic       incl
    );
        logic       found;
        logic [2:0] hit;
        int         pos;
        found = 1'b0;
        hit   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            pos = down ? (int'(base) - i) : (int'(base) + i);
            if (!incl) begin
                pos = down ? (pos - 1) : (pos + 1);
            end
            if (!found && (pos >= 0) && (pos <= 7) && !mask[pos[2:0]]) begin
                found = 1'b1;
                hit   = pos[2:0];
            end
        end
        return {found, hit};
    endfunction

    assign w_accept = (r_state == S_IDLE) && start && !stop;

`ifdef SCAN_SKIP_EN
    logic [7:0] r_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= 8'h00;
        end else if (w_accept) begin
            r_mask <= skip_mask;
        end
    end

    assign w_mask_in   = skip_mask;
    assign w_scan_mask = r_mask;
`else
    assign w_mask_in   = 8'h00;
    assign w_scan_mask = 8'h00;
`endif

    assign w_first_new = scan_from(w_mask_in,   dir   ? 3'd7 : 3'd0, dir,   1'b1);
    assign w_first_lat = scan_from(w_scan_mask, r_dir ? 3'd7 : 3'd0, r_dir, 1'b1);
    assign w_next      = scan_from(w_scan_mask, r_code,              r_dir, 1'b0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_code     <= 3'd0;
            r_cnt      <= c_DWELL_ZERO;
            r_dwell_m1 <= c_DWELL_ZERO;
            r_dir      <= 1'b0;
            r_loop     <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_code     <= w_nxt_code;
            r_cnt      <= w_nxt_cnt;
            r_dwell_m1 <= w_nxt_dwell_m1;
            r_dir      <= w_nxt_dir;
            r_loop     <= w_nxt_loop;
            r_valid    <= (w_nxt_state == S_HOLD);
            r_busy     <= (w_nxt_state == S_HOLD);
            r_done     <= w_nxt_done;
            r_wrap     <= w_nxt_wrap;
        end
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_code     = r_code;
        w_nxt_cnt      = r_cnt;
        w_nxt_dwell_m1 = r_dwell_m1;
        w_nxt_dir      = r_dir;
        w_nxt_loop     = r_loop;
        w_nxt_done     = 1'b0;
        w_nxt_wrap     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_nxt_code = 3'd0;
                w_nxt_cnt  = c_DWELL_ZERO;
                if (w_accept) begin
                    w_nxt_dir      = dir;
                    w_nxt_loop     = loop;
                    // A zero dwell behaves as a one-cycle dwell.
                    w_nxt_dwell_m1 = (dwell == c_DWELL_ZERO) ? c_DWELL_ZERO
                                                             : (dwell - c_DWELL_ONE);
                    if (w_first_new[3]) begin
                        w_nxt_state = S_HOLD;
                        w_nxt_code  = w_first_new[2:0];
                    end else begin
                        w_nxt_state = S_DONE;
                        w_nxt_done  = 1'b1;
                    end
                end
            end

            S_HOLD: begin
                if (stop) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_code  = 3'd0;
                    w_nxt_cnt   = c_DWELL_ZERO;
                end else if (r_cnt == r_dwell_m1) begin
                    w_nxt_cnt = c_DWELL_ZERO;
                    if (w_next[3]) begin
                        w_nxt_code = w_next[2:0];
                    end else if (r_loop) begin
                        w_nxt_code = w_first_lat[2:0];
                        w_nxt_wrap = 1'b1;
                    end else begin
                        w_nxt_state = S_DONE;
                        w_nxt_code  = 3'd0;
                        w_nxt_done  = 1'b1;
                    end
                end else begin
                    w_nxt_cnt = r_cnt + c_DWELL_ONE;
                end
            end

            S_DONE: begin
                w_nxt_state = S_IDLE;
                w_nxt_code  = 3'd0;
                w_nxt_cnt   = c_DWELL_ZERO;
            end

            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_code  = 3'd0;
                w_nxt_cnt   = c_DWELL_ZERO;
            end
        endcase
    end

    // The code register is cleared whenever no scan is active.
    assign A     = r_code[2];
    assign B     = r_code[1];
    assign C     = r_code[0];
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;
    assign wrap  = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_decode_scan_ctrl.sv
//==============================================================================
// Module      : tb_decode_scan_ctrl
// Description : Scoreboard bench for decode_scan_ctrl; expected per-cycle
//               output vectors are queued at start and compared each cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_decode_scan_ctrl;

    localparam int DWELL_W = 8;
    localparam logic [6:0] c_IDLE_VEC = 7'b000_0000;
    localparam logic [6:0] c_DONE_VEC = 7'b000_0010;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               dir = 1'b0;
    logic               loop = 1'b0;
    logic [DWELL_W-1:0] dwell = '0;
    logic [7:0]         skip_mask = 8'h00;
    logic               A, B, C, valid, busy, done, wrap;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [6:0] exp_q[$];
    logic [6:0] mon_exp;

    always #5 clk = ~clk;

    decode_scan_ctrl #(.DWELL_W(DWELL_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .dir       (dir),
        .loop      (loop),
        .dwell     (dwell),
`ifdef SCAN_SKIP_EN
        .skip_mask (skip_mask),
`endif
        .A         (A),
        .B         (B),
        .C         (C),
        .valid     (valid),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    function automatic logic [6:0] obs();
        return {valid, A, B, C, busy, done, wrap};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check("scan_cycle {valid,A,B,C,busy,done,wrap}", 32'(obs()), 32'(mon_exp));
        end
    end

    // Entry 0 is the cycle in which start is driven; entry t+1 is cycle t of the scan.
    task automatic gen_expect(input logic d, input logic lp, input int dw,
                              input int n_stream, input int stop_idx);
        int         codes[$];
        int         dd, plen, p, r, c;
        logic [2:0] c3;
        logic [6:0] v;
        exp_q.push_back(c_IDLE_VEC);
        for (int i = 0; i < 8; i++) begin
            c = d ? (7 - i) : i;
            if (!skip_mask[c]) codes.push_back(c);
        end
        dd = (dw == 0) ? 1 : dw;
        for (int t = 0; t < n_stream; t++) begin
            v = c_IDLE_VEC;
            if (stop_idx >= 0 && (t + 1) > stop_idx) begin
                v = c_IDLE_VEC;
            end else if (codes.size() == 0) begin
                v = (t == 0) ? c_DONE_VEC : c_IDLE_VEC;
            end else begin
                plen = codes.size() * dd;
                p    = t / plen;
                r    = t % plen;
                if (!lp && p >= 1) begin
                    v = (t == plen) ? c_DONE_VEC : c_IDLE_VEC;
                end else begin
                    c3 = 3'(codes[r / dd]);
                    v  = {1'b1, c3, 1'b1, 1'b0, (p > 0 && r == 0)};
                end
            end
            exp_q.push_back(v);
        end
    endtask

    task automatic run_scan(input logic d, input logic lp, input int dw, input logic [7:0] m,
                            input int n_stream, input int stop_idx, input int extra_idx);
        @(posedge clk); #2;
        dir       = d;
        loop      = lp;
        dwell     = DWELL_W'(dw);
        skip_mask = m;
        start     = 1'b1;
        stop      = (stop_idx == 0);
        gen_expect(d, lp, dw, n_stream, stop_idx);
        for (int j = 1; j <= n_stream; j++) begin
            @(posedge clk); #2;
            start = (j == extra_idx);
            stop  = (j == stop_idx);
            // Scan parameters must be ignored once latched.
            dir   = 1'($urandom);
            loop  = 1'($urandom);
            dwell = DWELL_W'($urandom);
        end
        @(negedge clk); #1;
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_vec", 32'(obs()), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 32'(obs()), 32'd0);

        // Up, dwell 2, single pass; a second start while busy must be ignored.
        run_scan(1'b0, 1'b0, 2, 8'h00, 19, -1, 5);
        // Down, dwell 0 (acts as 1); start during the done cycle must be ignored.
        run_scan(1'b1, 1'b0, 0, 8'h00, 11, -1, 9);
        // Up loop, dwell 1, two wraps then stop.
        run_scan(1'b0, 1'b1, 1, 8'h00, 20, 18, -1);
        // Stop while code 3 is presented.
        run_scan(1'b0, 1'b0, 3, 8'h00, 15, 11, -1);
        // Down loop, dwell 2, wrap 0->7 then stop.
        run_scan(1'b1, 1'b1, 2, 8'h00, 24, 20, -1);
        // Start and stop together: stop wins.
        run_scan(1'b0, 1'b0, 1, 8'h00, 4, 0, -1);
        // Dwell at maximum for a short window, then stop.
        run_scan(1'b1, 1'b0, 255, 8'h00, 12, 10, -1);
`ifdef SCAN_SKIP_EN
        run_scan(1'b0, 1'b0, 1, 8'b1010_1010, 7, -1, -1);
        run_scan(1'b1, 1'b0, 2, 8'b0110_0101, 11, -1, -1);
        run_scan(1'b0, 1'b0, 3, 8'hFF, 3, -1, -1);
        run_scan(1'b0, 1'b1, 2, 8'hEF, 10, 9, -1);
`endif

        // Asynchronous reset in the middle of a looping scan.
        @(posedge clk); #2;
        dir = 1'b0; loop = 1'b1; dwell = DWELL_W'(3); start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check("pre_reset_valid", 32'(valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", 32'(obs()), 32'd0);
        @(negedge clk);
        check("async_reset_held", 32'(obs()), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_idle", 32'(obs()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
